// File: rtl/shifter_pipelined.sv
// ============================================================================
// Module   : shifter_pipelined
// Purpose  : L-stage pipelined barrel shifter (SLL/SRL/SRA, optional ROR)
//            with valid/ready handshakes on both sides.
//            Define SHIFTER_PIPELINED_ROTATE_EN to make op 11 a rotate-right;
//            without it op 11 behaves as SRL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_pipelined #(
    parameter int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [L-1:0] in_shamt,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_sra = 2'b10;
`ifdef SHIFTER_PIPELINED_ROTATE_EN
    localparam logic [1:0] c_op_ror = 2'b11;
`endif

    // Stage registers; shift metadata is only kept where a later stage needs it.
    logic [N-1:0] r_data  [L];
    logic         r_valid [L];
    logic [L-1:0] r_rem   [L-1];
    logic [1:0]   r_op    [L-1];
    logic         r_sign  [L-1];

    logic [N-1:0] w_src_data  [L];
    logic [L-1:0] w_src_rem   [L];
    logic [1:0]   w_src_op    [L];
    logic         w_src_sign  [L];
    logic         w_src_valid [L];
    logic [N-1:0] w_shift     [L];
    logic [L-1:0] w_adv;
    logic [L-1:0] w_ready;
    logic [L-1:0] w_load;

    function automatic logic [N-1:0] f_stage(input logic [N-1:0] d,
                                             input logic [1:0]   op,
                                             input logic         sign,
                                             input int           s);
        logic [N-1:0] ones;
        ones = '1;
        case (op)
            c_op_sll: f_stage = d << s;
            c_op_sra: f_stage = (d >> s) | (sign ? ~(ones >> s) : '0);
`ifdef SHIFTER_PIPELINED_ROTATE_EN
            c_op_ror: f_stage = (d >> s) | (d << (N - s));
`endif
            default:  f_stage = d >> s;
        endcase
    endfunction

    for (genvar k = 0; k < L; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_src_data[k]  = in_data;
            assign w_src_rem[k]   = in_shamt;
            assign w_src_op[k]    = in_op;
            assign w_src_sign[k]  = in_data[N-1];
            assign w_src_valid[k] = in_valid;
        end else begin : g_next
            assign w_src_data[k]  = r_data[k-1];
            assign w_src_rem[k]   = r_rem[k-1];
            assign w_src_op[k]    = r_op[k-1];
            assign w_src_sign[k]  = r_sign[k-1];
            assign w_src_valid[k] = r_valid[k-1];
        end
        // Remaining shamt is kept right-aligned, so bit 0 always selects 2^k here.
        assign w_shift[k] = w_src_rem[k][0]
                          ? f_stage(w_src_data[k], w_src_op[k], w_src_sign[k], 1 << k)
                          : w_src_data[k];
        assign w_load[k]  = w_src_valid[k] & w_ready[k];
    end

    // Ready chain runs from the output back to the input in one pass.
    always_comb begin
        w_adv   = '0;
        w_ready = '0;
        for (int k = L - 1; k >= 0; k--) begin
            if (k == L - 1)
                w_adv[k] = r_valid[k] & out_ready;
            else
                w_adv[k] = r_valid[k] & w_ready[k+1];
            w_ready[k] = ~r_valid[k] | w_adv[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
            end
            for (int k = 0; k < L - 1; k++) begin
                r_rem[k]  <= '0;
                r_op[k]   <= '0;
                r_sign[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < L; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= w_shift[k];
                end else if (w_adv[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            for (int k = 0; k < L - 1; k++) begin
                if (w_load[k]) begin
                    r_rem[k]  <= w_src_rem[k] >> 1;
                    r_op[k]   <= w_src_op[k];
                    r_sign[k] <= w_src_sign[k];
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < L; k++)
            busy = busy | r_valid[k];
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[L-1];
    assign out_data  = r_data[L-1];

endmodule

`default_nettype wire

// File: tb/tb_shifter_pipelined.sv
// ============================================================================
// Module   : tb_shifter_pipelined
// Purpose  : Directed self-checking bench for shifter_pipelined (N = 32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shifter_pipelined;

    localparam int c_n = 32;
    localparam int c_l = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [c_n-1:0] in_data;
    logic [c_l-1:0] in_shamt;
    logic [1:0]     in_op;
    logic           out_valid;
    logic           out_ready;
    logic [c_n-1:0] out_data;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    shifter_pipelined #(.N(c_n)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One isolated op: latency counts edges from the accepting edge inclusive.
    task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] op, input logic [31:0] exp);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_shamt = s; in_op = op; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, c_l);
        check(tag, out_data, exp);
    endtask

    logic [31:0] exp_q [$];
    logic [31:0] held;
    int first_edge, n_out, ready_low, acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        run_one("sll_31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        run_one("srl_4", 32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000);
        run_one("sra_4_neg", 32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000);
        run_one("sra_4_pos", 32'h7000_0000, 5'd4, 2'b10, 32'h0700_0000);
        run_one("sra_31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
        run_one("sra_10", 32'h8000_0001, 5'd10, 2'b10, 32'hFFE0_0000);
        run_one("sll_21", 32'h0000_0001, 5'd21, 2'b00, 32'h0020_0000);
        run_one("srl_10", 32'hFFFF_FFFF, 5'd10, 2'b01, 32'h003F_FFFF);
        for (int op = 0; op < 4; op++)
            run_one($sformatf("zero_op%0d", op), 32'hDEAD_BEEF, 5'd0, op[1:0], 32'hDEAD_BEEF);
`ifdef SHIFTER_PIPELINED_ROTATE_EN
        run_one("ror_1", 32'h0000_0001, 5'd1, 2'b11, 32'h8000_0000);
        run_one("ror_8", 32'h1234_5678, 5'd8, 2'b11, 32'h7812_3456);
`else
        run_one("ror_1", 32'h0000_0001, 5'd1, 2'b11, 32'h0000_0000);
        run_one("ror_8", 32'h1234_5678, 5'd8, 2'b11, 32'h0012_3456);
`endif

        // Streaming: 8 back-to-back ops, results (i+1)<<i in order.
        first_edge = 0; n_out = 0; ready_low = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c <= 8) begin
                in_valid = 1'b1; in_data = 32'(c); in_shamt = 5'(c - 1); in_op = 2'b00;
                #1;
                if (!in_ready) ready_low++;
            end else begin
                in_valid = 1'b0;
            end
            if (c > 1 && out_valid) begin
                if (first_edge == 0) first_edge = c - 1;
                check($sformatf("stream_%0d", n_out), out_data, 32'(n_out + 1) << n_out);
                if (c - 1 != first_edge + n_out) ready_low += 100;
                n_out++;
            end
        end
        check("stream_in_ready_lows", ready_low, 0);
        check("stream_first_edge", first_edge, c_l);
        check("stream_count", n_out, 8);

        // Backpressure: fill with out_ready low, then drain.
        exp_q.delete(); acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1;
            in_data = 32'hA0 + 32'(acc); in_shamt = 5'd4; in_op = 2'b00;
            #1;
            if (in_ready) begin
                exp_q.push_back((32'hA0 + 32'(acc)) << 4);
                acc++;
            end
        end
        check("bp_accepted", acc, 5);
        check("bp_in_ready", in_ready, 0);
        check("bp_busy", busy, 1);
        held = out_data;
        repeat (3) @(negedge clk);
        check("bp_stable", out_data, held);
        check("bp_head", out_data, 32'hA00);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("bp_valid_%0d", j), out_valid, 1);
            check($sformatf("bp_data_%0d", j), out_data, (j < exp_q.size()) ? exp_q[j] : 32'hX);
            @(negedge clk);
            #1;
        end
        check("bp_drained", out_valid, 0);
        check("bp_idle", busy, 0);

        // Reset with three ops in flight.
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'hFFFF_0000; in_shamt = 5'd8; in_op = 2'b01;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        run_one("post_rst", 32'h0000_00F0, 5'd3, 2'b00, 32'h0000_0780);
        check("post_rst_busy_end", busy, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
